// File: rtl/vram_pkg.sv
// Shared constants, FSM state type and address-range helper for the
// double-buffered Game-of-Life frame buffer.
package vram_pkg;

  localparam int unsigned GRID_W = 20;
  localparam int unsigned GRID_H = 15;
  localparam int unsigned CELLS  = GRID_W * GRID_H;
  localparam int unsigned WORDS  = CELLS / 4;
  localparam int unsigned AW     = 7;

  localparam logic [31:0] CLEAR_VAL = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    WAIT_VBL
  } state_e;

  // Only words 0..WORDS-1 of each bank hold cells.
  function automatic logic in_range(input logic [AW-1:0] addr);
    return 32'(addr) < WORDS;
  endfunction

endpackage

// File: rtl/vram_dblbuf_if.sv
// Scan-out and CPU-side signals of the frame buffer, grouped for port use.
// slave is the frame buffer side, master the core/scan-out side.
interface vram_dblbuf_if;
  import vram_pkg::*;

  logic [8:0]    vaddr;
  logic [31:0]   vdata;
  logic          vga_vs_n;
  logic          cpu_we;
  logic          cpu_re;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [3:0]    cpu_wmask;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic          swap_req;
  logic          clear_req;
  logic          busy;
  logic          front_sel;

  modport slave (
    input  vaddr, vga_vs_n, cpu_we, cpu_re, cpu_addr, cpu_wdata, cpu_wmask,
           swap_req, clear_req,
    output vdata, cpu_rdata, cpu_ready, busy, front_sel
  );

  modport master (
    output vaddr, vga_vs_n, cpu_we, cpu_re, cpu_addr, cpu_wdata, cpu_wmask,
           swap_req, clear_req,
    input  vdata, cpu_rdata, cpu_ready, busy, front_sel
  );

endinterface

// File: rtl/vram_bank.sv
// One frame-buffer bank: byte-masked write port, free-running scan-out read
// port and an enabled CPU read port whose output holds between reads.
module vram_bank
  import vram_pkg::*;
(
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wmask,
  input  logic [AW-1:0] i_raddr_a,
  output logic [31:0]   o_rdata_a,
  input  logic          i_re_b,
  input  logic [AW-1:0] i_raddr_b,
  output logic [31:0]   o_rdata_b
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata_a;
  logic [31:0] r_rdata_b;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wmask[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    r_rdata_a <= r_mem[i_raddr_a];
    if (i_re_b) r_rdata_b <= r_mem[i_raddr_b];
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/vram_dblbuf.sv
// Double-buffered frame buffer: front bank feeds scan-out, CPU and clear engine
// own the back bank, page flips commit on the vsync falling edge.
module vram_dblbuf
  import vram_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  vram_dblbuf_if.slave  bus
);

  state_e        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_swap_pending;
  logic          r_front_sel;
  logic          r_vs;
  logic          r_busy;
  logic          r_ready;
  logic          r_vsel;
  logic          r_vok;
  logic          r_csel;
  logic          r_cok;

  logic          w_vbl_start;
  logic          w_cpu_wr;
  logic          w_cpu_rd;
  logic          w_clr_wr;
  logic          w_any_wr;
  logic [AW-1:0] w_vwaddr;
  logic [AW-1:0] w_waddr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wmask;
  logic [1:0]    w_we;
  logic [1:0]    w_re_b;
  logic [31:0]   w_vq [2];
  logic [31:0]   w_cq [2];
  logic          w_unused;

  assign w_vwaddr    = bus.vaddr[8:2];
  assign w_unused    = ^bus.vaddr[1:0];
  assign w_vbl_start = r_vs & ~bus.vga_vs_n;
  assign w_cpu_wr    = bus.cpu_we & r_ready & in_range(bus.cpu_addr);
  assign w_cpu_rd    = bus.cpu_re & r_ready;
  assign w_clr_wr    = (r_state == CLEAR);
  assign w_any_wr    = w_cpu_wr | w_clr_wr;

  // CPU is locked out during CLEAR, so the clear engine owns the write port then.
  always_comb begin
    w_waddr = bus.cpu_addr;
    w_wdata = bus.cpu_wdata;
    w_wmask = bus.cpu_wmask;
    if (w_clr_wr) begin
      w_waddr = r_cnt;
      w_wdata = CLEAR_VAL;
      w_wmask = 4'hF;
    end
  end

  assign w_we[0]   = w_any_wr & r_front_sel;
  assign w_we[1]   = w_any_wr & ~r_front_sel;
  assign w_re_b[0] = w_cpu_rd & r_front_sel;
  assign w_re_b[1] = w_cpu_rd & ~r_front_sel;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    vram_bank u_bank (
      .clk       (clk),
      .i_we      (w_we[g]),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_wmask   (w_wmask),
      .i_raddr_a (w_vwaddr),
      .o_rdata_a (w_vq[g]),
      .i_re_b    (w_re_b[g]),
      .i_raddr_b (bus.cpu_addr),
      .o_rdata_b (w_cq[g])
    );
  end

  // Remember which bank and whether the address was valid for each read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsel <= 1'b0;
      r_vok  <= 1'b0;
      r_csel <= 1'b0;
      r_cok  <= 1'b0;
    end else begin
      r_vsel <= r_front_sel;
      r_vok  <= in_range(w_vwaddr);
      if (w_cpu_rd) begin
        r_csel <= ~r_front_sel;
        r_cok  <= in_range(bus.cpu_addr);
      end
    end
  end

  assign bus.vdata     = r_vok ? w_vq[r_vsel] : '0;
  assign bus.cpu_rdata = r_cok ? w_cq[r_csel] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_swap_pending <= 1'b0;
      r_front_sel    <= 1'b0;
      r_vs           <= 1'b1;
      r_busy         <= 1'b0;
      r_ready        <= 1'b0;
    end else begin
      r_vs <= bus.vga_vs_n;
      unique case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (bus.clear_req) begin
            r_state        <= CLEAR;
            r_cnt          <= '0;
            r_swap_pending <= bus.swap_req;
            r_busy         <= 1'b1;
            r_ready        <= 1'b0;
          end else if (bus.swap_req) begin
            r_state        <= WAIT_VBL;
            r_swap_pending <= 1'b1;
            r_busy         <= 1'b1;
          end
        end
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.swap_req) r_swap_pending <= 1'b1;
          if (32'(r_cnt) == WORDS - 1) begin
            r_ready <= 1'b1;
            if (r_swap_pending | bus.swap_req) begin
              r_state <= WAIT_VBL;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        WAIT_VBL: begin
          if (w_vbl_start) begin
            r_front_sel    <= ~r_front_sel;
            r_swap_pending <= 1'b0;
            r_state        <= IDLE;
            r_busy         <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.front_sel = r_front_sel;

endmodule

// File: doc/vram_dblbuf.md
Name: vram_dblbuf

Overview:
- Double-buffered Game-of-Life frame buffer that sits directly upstream of the VGA scan-out stage.
- Serves the scan-out byte address `vaddr[8:0]` with 32-bit `vdata` from the front bank.
- The RISC-V core writes the back bank through a word port.
- A page swap is requested by the core and committed only at the start of vertical blanking, so the display never tears.
- A hardware clear engine fills the back bank between generations.

Parameters:
- CELLS, 300, display cells (20x15, one byte per cell).
- WORDS, 75, words per bank (CELLS/4).
- AW, 7, word address width per bank.
- CLEAR_VAL, 32'h00000000, fill word written by the clear engine.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- vaddr  in  9  scan-out byte index (col + row*20).
- vdata  out  32  front-bank word containing byte vaddr; byte vaddr[1:0]=0 in [31:24], 3 in [7:0].
- vga_vs_n  in  1  VGA vertical sync, active low (from scan-out).
- cpu_we  in  1  write strobe to back bank.
- cpu_re  in  1  read strobe from back bank.
- cpu_addr  in  AW  back-bank word address.
- cpu_wdata  in  32  write data.
- cpu_wmask  in  4  byte enables; bit3 -> [31:24].
- cpu_rdata  out  32  back-bank read data.
- cpu_ready  out  1  high when a CPU access is accepted this cycle.
- swap_req  in  1  one-cycle pulse: request page flip.
- clear_req  in  1  one-cycle pulse: fill back bank with CLEAR_VAL.
- busy  out  1  clear running or swap pending.
- front_sel  out  1  bank currently displayed.

Behaviour:
- Reset: all outputs go low. That means vdata=0, cpu_rdata=0, cpu_ready=0 during reset, busy=0, front_sel=0. FSM goes to IDLE, swap_pending=0, vs edge register=1. RAM contents are not reset.
- Storage: two banks of 2^AW words (only 0..WORDS-1 used), one synchronous-read RAM per bank.
- Scan-out read:
  - Word address = vaddr[8:2]; vdata is valid 1 cycle after vaddr.
  - Reads bank front_sel.
  - If vaddr[8:2] >= WORDS, vdata=0.
- CPU port:
  - Always targets bank ~front_sel.
  - Write with cpu_we && cpu_ready: byte-masked write, same cycle.
  - cpu_re && cpu_ready: cpu_rdata valid next cycle. It holds its value otherwise.
  - cpu_addr >= WORDS: write dropped, read returns 0.
  - cpu_ready = (state != CLEAR).
- Vblank detect:
  - vs_q <= vga_vs_n each cycle.
  - vbl_start = vs_q & ~vga_vs_n (falling edge).
- FSM states and transitions:
  - IDLE:
    - clear_req -> CLEAR with cnt=0.
    - else swap_req -> WAIT_VBL.
    - If both are asserted in the same cycle, clear wins and swap_pending is set.
  - CLEAR:
    - Writes CLEAR_VAL to back[cnt] each cycle; cnt increments.
    - At cnt==WORDS-1 the last write happens. Next state is WAIT_VBL if swap_pending, else IDLE. Exactly WORDS cycles.
    - swap_req in CLEAR sets swap_pending. clear_req in CLEAR is ignored.
  - WAIT_VBL:
    - On vbl_start, toggle front_sel, clear swap_pending, go to IDLE.
    - swap_req and clear_req are ignored here (no double flip).
    - A CPU write coincident with the toggle cycle goes to the pre-toggle back bank.
- busy = (state != IDLE).
- Reset mid-clear: abort immediately; the partially cleared bank is left as is.
- Reset during WAIT_VBL: swap is lost and front_sel=0.
- front_sel changes only on a vbl_start cycle; vdata switches banks from the next read.

Decomposition:
- Shared package `vram_pkg`:
  - Constants: GRID_W=20, GRID_H=15, CELLS, WORDS, AW, CLEAR_VAL.
  - FSM state enum: IDLE, CLEAR, WAIT_VBL.
- Sub-module `vram_bank`:
  - Single-port-write/dual-read byte-masked RAM, depth 2^AW, synchronous read. Instantiated twice.
- Bank steering and the FSM live in the top level.

Test Plan:
- Write 32'hAABBCCDD, mask 4'hF, to word 5 (back bank 1). Pulse swap_req, then drive vga_vs_n 1->0. -> front_sel=1 the cycle after the edge; vaddr=21 gives vdata=32'hAABBCCDD one cycle later.
- Mask test: write 32'h11223344 with mask 4'b0101 over a word holding 32'hAABBCCDD. -> cpu_rdata=32'hAA22CC44.
- Clear:
  - Pulse clear_req. -> busy=1 and cpu_ready=0 for exactly 75 cycles.
  - Afterwards, words 0..74 of the back bank read 0 and the front bank is unchanged.
- swap_req during clear. -> no flip before the clear finishes; the flip occurs on the first vsync falling edge after the clear ends.
- Two swap_req pulses before vsync. -> exactly one toggle.
- Out-of-range access: cpu_addr=75 read returns 0; vaddr=300 gives vdata=0.
- Reset asserted mid-clear: outputs go to 0 and front_sel=0 asynchronously; busy=0 after release.
